imem_fetch_unit: RTL and testbench
==================================

// Module: imem_fetch_unit
// PURPOSE
//  Instruction-memory front end sitting directly upstream of the datapath fetch stage.
//  Takes PCF, issues one request at a time to a variable-latency instruction memory over a
//  valid/ready request + valid response channel, buffers the returned word, and drives InstrF.
//  Raises FetchStall to the hazard/control unit until the word for the current PCF is valid.
//  Discards in-flight fetches on a redirect and flags misaligned, bus-error and timeout faults.
// PARAMETERS
//  NOP_INSTR      32'h0000_0013  word driven on InstrF when no valid instruction (addi x0,x0,0)
//  TIMEOUT_CYCLES 64             max cycles in WAIT before a timeout fault; must be >= 2
// PORTS
//  clk            in   1   clock; all state updates on rising edge
//  reset          in   1   asynchronous, active-high reset
//  PCF            in   32  fetch address from datapath PC
//  StallF         in   1   fetch stall from control; buffered word is not consumed while high
//  FlushD         in   1   redirect (branch/jump taken); PCF is the new target
//  InstrF         out  32  instruction to the IF/ID register
//  FetchStall     out  1   1 = InstrF is not valid for PCF; control must stall F/D
//  FetchFault     out  1   1 = fetch fault active (misaligned, bus error or timeout)
//  imem_req_valid out  1   request valid
//  imem_req_addr  out  32  request word address
//  imem_req_ready in   1   memory accepts request
//  imem_rsp_valid in   1   response valid; one response per accepted request
//  imem_rsp_data  in   32  response word
//  imem_rsp_err   in   1   bus error, qualified by imem_rsp_valid
// BEHAVIOUR
//  Reset (async, active-high): state=IDLE, buffer invalid, timeout counter=0.
//   While reset is high and in IDLE: imem_req_valid=0, imem_req_addr=0, InstrF=NOP_INSTR,
//   FetchStall=1, FetchFault=0.
//  Internal buffer: buf_data[31:0], buf_addr[31:0], buf_valid.
//   hit = buf_valid && (buf_addr == PCF).
//  Outputs:
//   InstrF = buf_data when hit, else NOP_INSTR.
//   FetchStall = !hit && state != FAULT.
//   FetchFault = (state == FAULT).
//  States:
//   IDLE : unconditionally -> REQ on the next edge.
//   REQ  : if PCF[1:0] != 0 -> FAULT, no request issued.
//          Else imem_req_valid=1, imem_req_addr=PCF. On the edge with ready=1: latch
//          req_addr=PCF, clear counter, -> WAIT. PCF may change while waiting for ready;
//          the address is taken combinationally.
//   WAIT : counter increments each cycle.
//          rsp_valid && !err: buf_data=rsp_data, buf_addr=req_addr, buf_valid=1 -> HOLD.
//          rsp_valid && err: -> FAULT.
//          counter == TIMEOUT_CYCLES-1 with no response: -> FAULT.
//          FlushD=1 with no response this cycle: -> DRAIN.
//          FlushD=1 with the response in the same cycle: response dropped, buf_valid=0 -> REQ.
//   DRAIN: wait for the single outstanding response and discard it (data and err) -> REQ.
//          Timeout counter continues; expiry -> FAULT.
//   HOLD : hit && !StallF: word consumed; on the edge buf_valid=0 -> REQ.
//          hit && StallF: remain, InstrF held stable.
//          !hit (PCF redirected) or FlushD: buf_valid=0 -> REQ.
//   FAULT: no requests. InstrF=NOP_INSTR, FetchStall=0 so the NOP drains down the pipeline.
//          Leaves only on FlushD=1 -> REQ with the counter cleared.
//  Latency: request accepted on edge N with response at edge N+L -> InstrF valid and
//   FetchStall=0 from edge N+L. Sustained rate with zero-wait memory is 1 instr per 3 cycles
//   (REQ, WAIT, HOLD).
//  At most one outstanding request. imem_req_valid never asserts in WAIT, DRAIN or FAULT.
//  Reset mid-operation drops any outstanding request. The memory must also be reset by the
//   same reset so a stale response cannot arrive afterwards.
//  Counter width is $clog2(TIMEOUT_CYCLES)+1. It saturates and never wraps.
// TESTING
//  T1 reset then PCF=0x0, ready=1, rsp 1 cycle later data=0x00500093
//     -> req_addr=0x0; InstrF=0x00500093, FetchStall=0 in HOLD; REQ again after consume.
//  T2 hit with StallF=1 for 3 cycles -> InstrF stays 0x00500093, no new request,
//     FetchStall=0 throughout.
//  T3 WAIT on 0x8, FlushD pulse with PCF=0x40, stale rsp 0xDEADBEEF 2 cycles later
//     -> discarded, next req_addr=0x40, InstrF never 0xDEADBEEF.
//  T4 PCF=0x6 -> no request; FetchFault=1, InstrF=0x00000013, FetchStall=0;
//     FlushD with PCF=0x10 -> request 0x10.
//  T5 rsp_valid=1, rsp_err=1 -> FAULT. Separately, no response for TIMEOUT_CYCLES=64 cycles
//     -> FetchFault=1 on cycle 64.
//  T6 ready held 0 for 5 cycles while PCF=0x20 -> req_valid=1 stable with addr 0x20;
//     assert reset mid-WAIT -> IDLE outputs immediately (async).

Source files
------------

// File: rtl/imem_fetch_unit.sv
// rtl/imem_fetch_unit.sv - instruction memory front end with a one-word fetch buffer
// One request in flight at a time; redirects drain stale responses, faults park InstrF on a NOP.
module imem_fetch_unit #(
   parameter logic [31:0] NOP_INSTR      = 32'h0000_0013,
   parameter int          TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] PCF,
   input  logic        StallF,
   input  logic        FlushD,
   output logic [31:0] InstrF,
   output logic        FetchStall,
   output logic        FetchFault,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        imem_rsp_err
);
   localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] CNT_MAX = '1;

   typedef enum logic [2:0] {
      S_IDLE, S_REQ, S_WAIT, S_DRAIN, S_HOLD, S_FAULT
   } state_t;

   state_t        r_state;
   state_t        w_next_state;
   logic [31:0]   r_buf_data;
   logic [31:0]   r_buf_addr;
   logic [31:0]   r_req_addr;
   logic          r_buf_valid;
   logic [CW-1:0] r_cnt;
   logic          w_hit;
   logic          w_misaligned;
   logic          w_timeout;
   logic          w_accept;
   logic          w_load;

   assign w_hit        = r_buf_valid && (r_buf_addr == PCF);
   assign w_misaligned = (PCF[1:0] != 2'b00);
   assign w_timeout    = (r_cnt == TO_LAST);
   assign w_accept     = (r_state == S_REQ) && !w_misaligned && imem_req_ready;
   // A response that coincides with a redirect belongs to the old path and is dropped.
   assign w_load       = (r_state == S_WAIT) && imem_rsp_valid && !imem_rsp_err && !FlushD;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  w_next_state = S_REQ;
         S_REQ: begin
            if (w_misaligned)        w_next_state = S_FAULT;
            else if (imem_req_ready) w_next_state = S_WAIT;
         end
         S_WAIT: begin
            if (imem_rsp_valid) begin
               if (FlushD)            w_next_state = S_REQ;
               else if (imem_rsp_err) w_next_state = S_FAULT;
               else                   w_next_state = S_HOLD;
            end
            else if (w_timeout)      w_next_state = S_FAULT;
            else if (FlushD)         w_next_state = S_DRAIN;
         end
         S_DRAIN: begin
            if (imem_rsp_valid)      w_next_state = S_REQ;
            else if (w_timeout)      w_next_state = S_FAULT;
         end
         S_HOLD: begin
            if (!w_hit || FlushD || !StallF) w_next_state = S_REQ;
         end
         S_FAULT: begin
            if (FlushD)              w_next_state = S_REQ;
         end
         default:                    w_next_state = S_IDLE;
      endcase
   end

   always_comb begin
      imem_req_valid = (r_state == S_REQ) && !w_misaligned;
      imem_req_addr  = imem_req_valid ? PCF : 32'h0;
      InstrF         = w_hit ? r_buf_data : NOP_INSTR;
      FetchStall     = !w_hit && (r_state != S_FAULT);
      FetchFault     = (r_state == S_FAULT);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_buf_data  <= '0;
         r_buf_addr  <= '0;
         r_buf_valid <= 1'b0;
         r_req_addr  <= '0;
         r_cnt       <= '0;
      end else begin
         if (w_accept) begin
            r_req_addr <= PCF;
            r_cnt      <= '0;
         end else if ((r_state == S_WAIT || r_state == S_DRAIN) && r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
         end else if (r_state == S_FAULT && FlushD) begin
            r_cnt <= '0;
         end

         if (w_load) begin
            r_buf_data  <= imem_rsp_data;
            r_buf_addr  <= r_req_addr;
            r_buf_valid <= 1'b1;
         end else if (r_state == S_HOLD && w_next_state != S_HOLD) begin
            r_buf_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_imem_fetch_unit.sv
// tb/tb_imem_fetch_unit.sv - directed and randomized bench for imem_fetch_unit
// Random phase checks every delivered word against a word-per-address memory image.
module tb_imem_fetch_unit;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        reset;
   logic [31:0] PCF;
   logic        StallF;
   logic        FlushD;
   logic [31:0] InstrF;
   logic        FetchStall;
   logic        FetchFault;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        imem_rsp_err;

   int n_tests = 0;
   int n_fail  = 0;

   imem_fetch_unit #(.NOP_INSTR(NOP), .TIMEOUT_CYCLES(64)) dut (
      .clk(clk), .reset(reset), .PCF(PCF), .StallF(StallF), .FlushD(FlushD),
      .InstrF(InstrF), .FetchStall(FetchStall), .FetchFault(FetchFault),
      .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
      .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
      check({tag, "_req_addr"}, imem_req_addr, 32'h0);
      check({tag, "_instr"}, InstrF, NOP);
      check({tag, "_stall"}, 32'(FetchStall), 32'd1);
      check({tag, "_fault"}, 32'(FetchFault), 32'd0);
   endtask

   function automatic logic [31:0] memword(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h5A3C_0F96;
   endfunction

   logic [31:0] pc;
   logic [31:0] pend_addr;
   logic [31:0] fire_addr;
   logic        pend;
   logic        fire;
   logic        rsp_fire;
   logic        consumed;
   logic        flush;
   int          pend_cnt;
   int          retired;
   int          early_fault;

   initial begin
      reset = 1'b1; PCF = 32'h0; StallF = 1'b0; FlushD = 1'b0;
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; imem_rsp_err = 1'b0;
      #2;
      check_idle_outputs("reset");
      tick(); tick();

      // T1: basic fetch of address 0
      reset = 1'b0; PCF = 32'h0; imem_req_ready = 1'b1;
      tick();
      check("t1_req_valid", 32'(imem_req_valid), 32'd1);
      check("t1_req_addr", imem_req_addr, 32'h0);
      tick();
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0050_0093;
      #1;
      check("t1_wait_stall", 32'(FetchStall), 32'd1);
      check("t1_wait_noreq", 32'(imem_req_valid), 32'd0);
      tick();
      imem_rsp_valid = 1'b0; StallF = 1'b1;
      #1;
      check("t1_instr", InstrF, 32'h0050_0093);
      check("t1_stall", 32'(FetchStall), 32'd0);

      // T2: held by StallF for three cycles
      for (int i = 0; i < 3; i++) begin
         check("t2_instr", InstrF, 32'h0050_0093);
         check("t2_stall", 32'(FetchStall), 32'd0);
         check("t2_noreq", 32'(imem_req_valid), 32'd0);
         tick();
      end
      StallF = 1'b0;
      #1;
      check("t2_consume_instr", InstrF, 32'h0050_0093);
      tick();

      // T3: redirect while waiting on 0x8, stale response discarded
      PCF = 32'h8; imem_req_ready = 1'b1;
      #1;
      check("t3_req_valid", 32'(imem_req_valid), 32'd1);
      check("t3_req_addr", imem_req_addr, 32'h8);
      tick();
      imem_req_ready = 1'b0; FlushD = 1'b1; PCF = 32'h40;
      #1;
      check("t3_flush_stall", 32'(FetchStall), 32'd1);
      tick();
      FlushD = 1'b0;
      #1;
      check("t3_drain_noreq", 32'(imem_req_valid), 32'd0);
      tick();
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
      #1;
      check("t3_stale_instr", InstrF, NOP);
      check("t3_stale_noreq", 32'(imem_req_valid), 32'd0);
      tick();
      imem_rsp_valid = 1'b0; imem_req_ready = 1'b1;
      #1;
      check("t3_instr_not_stale", InstrF, NOP);
      check("t3_req_valid", 32'(imem_req_valid), 32'd1);
      check("t3_req_addr", imem_req_addr, 32'h40);
      tick();
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h02A0_0113;
      tick();
      imem_rsp_valid = 1'b0;
      #1;
      check("t3_new_instr", InstrF, 32'h02A0_0113);

      // T4: misaligned PC faults, FlushD recovers
      PCF = 32'h6;
      #1;
      check("t4_miss_stall", 32'(FetchStall), 32'd1);
      tick();
      check("t4_no_req", 32'(imem_req_valid), 32'd0);
      tick();
      check("t4_fault", 32'(FetchFault), 32'd1);
      check("t4_instr", InstrF, NOP);
      check("t4_stall", 32'(FetchStall), 32'd0);
      check("t4_noreq", 32'(imem_req_valid), 32'd0);
      tick();
      check("t4_fault_held", 32'(FetchFault), 32'd1);
      FlushD = 1'b1; PCF = 32'h10;
      tick();
      FlushD = 1'b0; imem_req_ready = 1'b1;
      #1;
      check("t4_fault_clear", 32'(FetchFault), 32'd0);
      check("t4_req_valid", 32'(imem_req_valid), 32'd1);
      check("t4_req_addr", imem_req_addr, 32'h10);
      tick();

      // T5: bus error, then timeout
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_err = 1'b1; imem_rsp_data = 32'h1234_5678;
      tick();
      imem_rsp_valid = 1'b0; imem_rsp_err = 1'b0;
      #1;
      check("t5_err_fault", 32'(FetchFault), 32'd1);
      check("t5_err_instr", InstrF, NOP);
      FlushD = 1'b1; PCF = 32'h14;
      tick();
      FlushD = 1'b0; imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      early_fault = 0;
      for (int i = 0; i < 64; i++) begin
         if (FetchFault) early_fault++;
         tick();
      end
      check("t5_no_early_timeout", 32'(early_fault), 32'd0);
      check("t5_timeout_fault", 32'(FetchFault), 32'd1);

      // T6: request held without ready, then async reset mid-WAIT
      FlushD = 1'b1; PCF = 32'h20;
      tick();
      FlushD = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("t6_req_valid", 32'(imem_req_valid), 32'd1);
         check("t6_req_addr", imem_req_addr, 32'h20);
         tick();
      end
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      #1;
      check("t6_wait_noreq", 32'(imem_req_valid), 32'd0);
      reset = 1'b1;
      #1;
      check_idle_outputs("t6_async_reset");
      tick();
      reset = 1'b0;

      // Random phase: sequential fetch with stalls, redirects and variable memory latency
      pc = 32'h100; pend = 1'b0; pend_cnt = 0; pend_addr = 32'h0;
      consumed = 1'b0; retired = 0;
      for (int c = 0; c < 800; c++) begin
         if (consumed) pc = pc + 32'd4;
         flush = ($urandom_range(0, 15) == 0);
         if (flush) pc = 32'($urandom_range(0, 1023)) << 2;
         PCF = pc; FlushD = flush;
         StallF = ($urandom_range(0, 3) == 0);
         imem_req_ready = ($urandom_range(0, 2) != 0);
         imem_rsp_valid = pend && (pend_cnt == 0);
         imem_rsp_data  = memword(pend_addr);
         imem_rsp_err   = 1'b0;
         #1;
         check("rnd_one_outstanding", 32'(imem_req_valid && pend), 32'd0);
         check("rnd_no_fault", 32'(FetchFault), 32'd0);
         if (imem_req_valid) check("rnd_req_addr", imem_req_addr, pc);
         if (!FetchStall) check("rnd_instr", InstrF, memword(pc));
         consumed = !FetchStall && !StallF && !flush;
         if (consumed) retired++;
         fire = imem_req_valid && imem_req_ready;
         fire_addr = imem_req_addr;
         rsp_fire = imem_rsp_valid;
         tick();
         if (rsp_fire) pend = 1'b0;
         else if (pend && pend_cnt > 0) pend_cnt--;
         if (fire) begin
            pend = 1'b1;
            pend_addr = fire_addr;
            pend_cnt = $urandom_range(0, 4);
         end
      end
      FlushD = 1'b0; StallF = 1'b0; imem_rsp_valid = 1'b0;
      check("rnd_progress", 32'(retired >= 40), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
